// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: command encoding,
// default parameter values and the command priority decoder.
package pc_sequencer_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_STEP      = 1;
    localparam int DEF_OFF_W     = 8;
    localparam int DEF_RAS_DEPTH = 4;
    localparam int DEF_RESET_VEC = 0;

    typedef enum logic [2:0] {
        CMD_INC  = 3'd0,
        CMD_JMP  = 3'd1,
        CMD_BR   = 3'd2,
        CMD_CALL = 3'd3,
        CMD_RET  = 3'd4
    } cmd_e;

    // ret > call > pWrite > br_valid > increment. A ret on an empty stack
    // cannot pop, so it degrades to a plain increment (and drops any call).
    function automatic cmd_e decode_cmd(
        input logic ret,
        input logic call,
        input logic pwrite,
        input logic br_valid,
        input logic ras_empty
    );
        cmd_e cmd;
        if (ret && !ras_empty)
            cmd = CMD_RET;
        else if (ret)
            cmd = CMD_INC;
        else if (call)
            cmd = CMD_CALL;
        else if (pwrite)
            cmd = CMD_JMP;
        else if (br_valid)
            cmd = CMD_BR;
        else
            cmd = CMD_INC;
        return cmd;
    endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO: push/pop with combinational top, full and empty.
// Contents are not reset; only the entry count is.
module ras_stack
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ras_stack: RAS_DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign top_idx = PTR_W'(count - CNT_W'(1));
    assign wr_idx  = count[PTR_W-1:0];
    assign top     = mem[top_idx];

    assign do_pop  = pop && !empty;
    // A push with a simultaneous pop replaces the top entry, so it fits even when full.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[do_pop ? top_idx : wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: stall, stepped increment, relative branch,
// absolute jump and call/return through an internal return-address stack.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               STEP      = DEF_STEP,
    parameter int               OFF_W     = DEF_OFF_W,
    parameter int               RAS_DEPTH = DEF_RAS_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pWrite,
    input  logic [WIDTH-1:0] temp_in,
    input  logic             br_valid,
    input  logic [OFF_W-1:0] br_off,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    cmd_e                    cmd;
    logic signed [OFF_W-1:0] off_s;
    logic [WIDTH-1:0]        off_ext;
    logic [WIDTH-1:0]        pc_inc;
    logic [WIDTH-1:0]        pc_br;
    logic [WIDTH-1:0]        pc_next;
    logic [WIDTH-1:0]        ras_top;
    logic                    push;
    logic                    pop;
    logic                    err_set;

    assign cmd     = decode_cmd(ret, call, pWrite, br_valid, ras_empty);

    assign off_s   = br_off;
    assign off_ext = WIDTH'(off_s);
    assign pc_inc  = out + WIDTH'(STEP);
    assign pc_br   = out + off_ext;

    always_comb begin
        pc_next = pc_inc;
        case (cmd)
            CMD_RET:  pc_next = ras_top;
            CMD_CALL: pc_next = temp_in;
            CMD_JMP:  pc_next = temp_in;
            CMD_BR:   pc_next = pc_br;
            default:  pc_next = pc_inc;
        endcase
    end

    // Overflowing calls still jump; the stack simply refuses the push.
    assign push    = en && (cmd == CMD_CALL);
    assign pop     = en && (cmd == CMD_RET);
    assign err_set = en && ((ret && ras_empty) || (!ret && call && ras_full));

    always_ff @(posedge clk) begin
        if (rst) begin
            out     <= RESET_VEC;
            ras_err <= 1'b0;
        end else if (en) begin
            out <= pc_next;
            if (err_set) begin
                ras_err <= 1'b1;
            end
        end
    end

    ras_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model checked every cycle,
// plus literal expectations at key points of the directed sequence.
module tb_pc_sequencer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        pWrite = 1'b0;
    logic [15:0] temp_in = '0;
    logic        br_valid = 1'b0;
    logic [7:0]  br_off = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] out;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    logic [15:0] m_pc;
    logic [15:0] m_q[$];
    bit          m_err;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pWrite    (pWrite),
        .temp_in   (temp_in),
        .br_valid  (br_valid),
        .br_off    (br_off),
        .call      (call),
        .ret       (ret),
        .out       (out),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
    );

    // Reference behaviour, applied once per rising edge with the sampled inputs.
    task automatic model_step();
        if (rst) begin
            m_pc = 16'h0000;
            m_q.delete();
            m_err = 1'b0;
            chk_on = 1'b1;
        end else if (en) begin
            if (ret) begin
                if (m_q.size() > 0) begin
                    m_pc = m_q.pop_back();
                end else begin
                    m_pc = m_pc + 16'd1;
                    m_err = 1'b1;
                end
            end else if (call) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pc + 16'd1);
                else m_err = 1'b1;
                m_pc = temp_in;
            end else if (pWrite) begin
                m_pc = temp_in;
            end else if (br_valid) begin
                m_pc = 16'(int'(m_pc) + int'($signed(br_off)));
            end else begin
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic pw, input logic [15:0] ti,
                       input logic bv, input logic [7:0] bo, input logic ca, input logic re);
        rst = r; en = e; pWrite = pw; temp_in = ti;
        br_valid = bv; br_off = bo; call = ca; ret = re;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic inc();              cyc(0, 1, 0, 16'h0, 0, 8'h0, 0, 0); endtask
    task automatic jmp(input logic [15:0] t); cyc(0, 1, 1, t, 0, 8'h0, 0, 0); endtask
    task automatic br(input logic [7:0] o);   cyc(0, 1, 0, 16'h0, 1, o, 0, 0); endtask
    task automatic call_to(input logic [15:0] t); cyc(0, 1, 0, t, 0, 8'h0, 1, 0); endtask
    task automatic do_ret();           cyc(0, 1, 0, 16'h0, 0, 8'h0, 0, 1); endtask

    task automatic lit(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (out !== m_pc || ras_empty !== (m_q.size() == 0) ||
                ras_full !== (m_q.size() == DEPTH) || ras_err !== m_err) begin
                bad++;
                $display("FAIL model_cmp t=%0t out act=%h req=%h empty act=%b req=%b full act=%b req=%b err act=%b req=%b",
                         $time, out, m_pc, ras_empty, m_q.size() == 0,
                         ras_full, m_q.size() == DEPTH, ras_err, m_err);
            end
        end
    end

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 16'h0, 0, 8'h0, 0, 0);
        lit("reset_out", out, 16'h0000);
        lit("reset_empty", {15'b0, ras_empty}, 16'd1);
        lit("reset_full", {15'b0, ras_full}, 16'd0);
        lit("reset_err", {15'b0, ras_err}, 16'd0);

        for (int i = 1; i <= 4; i++) begin
            inc();
            lit("inc_seq", out, 16'(i));
        end
        lit("inc_empty", {15'b0, ras_empty}, 16'd1);

        jmp(16'h0040);
        lit("jump", out, 16'h0040);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 16'h1234, 1, 8'h05, 1, 1);
            lit("stall_hold", out, 16'h0040);
        end
        lit("stall_err", {15'b0, ras_err}, 16'd0);

        br(8'hFE);
        lit("branch_back", out, 16'h003E);
        br(8'h10);
        lit("branch_fwd", out, 16'h004E);
        jmp(16'hFFFF);
        inc();
        lit("wrap", out, 16'h0000);

        jmp(16'h0010);
        call_to(16'h0100);
        lit("call", out, 16'h0100);
        inc();
        inc();
        lit("call_body", out, 16'h0102);
        do_ret();
        lit("ret", out, 16'h0011);
        lit("ret_empty", {15'b0, ras_empty}, 16'd1);

        jmp(16'h1000);
        call_to(16'h2000);
        call_to(16'h3000);
        call_to(16'h4000);
        call_to(16'h5000);
        lit("fill_full", {15'b0, ras_full}, 16'd1);
        lit("fill_err", {15'b0, ras_err}, 16'd0);
        call_to(16'h0200);
        lit("ovf_jump", out, 16'h0200);
        lit("ovf_err", {15'b0, ras_err}, 16'd1);
        do_ret();
        lit("lifo_0", out, 16'h4001);
        do_ret();
        lit("lifo_1", out, 16'h3001);
        do_ret();
        lit("lifo_2", out, 16'h2001);
        do_ret();
        lit("lifo_3", out, 16'h1001);
        do_ret();
        lit("udf_inc", out, 16'h1002);
        lit("udf_err", {15'b0, ras_err}, 16'd1);

        jmp(16'h0020);
        call_to(16'h0500);
        cyc(0, 1, 1, 16'h0777, 1, 8'h03, 1, 1);
        lit("call_ret_same", out, 16'h0021);
        lit("call_ret_empty", {15'b0, ras_empty}, 16'd1);
        inc();
        call_to(16'h0600);
        cyc(1, 0, 0, 16'h0, 0, 8'h0, 1, 0);
        lit("rst_mid_out", out, 16'h0000);
        lit("rst_mid_err", {15'b0, ras_err}, 16'd0);
        lit("rst_mid_empty", {15'b0, ras_empty}, 16'd1);
        inc();
        lit("post_rst_inc", out, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
